// File: rtl/host_uart_ui_rx_pkg.sv
// Shared types and constants for the host UART receiver that drives ui_in.
// Sample indices assume 16 ticks per bit.
package host_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [3:0] SAMPLE_A      = 4'd7;
  localparam logic [3:0] SAMPLE_B      = 4'd8;
  localparam logic [3:0] SAMPLE_DECIDE = 4'd9;
  localparam logic [3:0] BIT_END       = 4'd15;

  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/host_uart_ui_rx_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, restartable via clear.
module uart_baud_tick_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (tick)    cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/host_uart_ui_rx.sv
// 8N1 UART receiver with 3-sample majority vote; each good byte is latched
// into ui_value, which holds the core's ui_in bus between updates.
module host_uart_ui_rx
  import host_uart_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 100000000,
  parameter int         BAUD        = 115200,
  parameter int         OVERSAMPLE  = 16,
  parameter logic [7:0] UI_RESET    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] ui_value,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);

  logic [1:0] sync;
  logic       rxs;
  state_t     state, state_n;
  logic [3:0] samp_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift_reg;
  logic       s_a, s_b;
  logic       tick, tick_clear;
  logic       maj, at_decide, at_end;
  logic       valid_n, err_n;

  assign rxs = sync[1];

  // Counters are held at zero while idle, so timing restarts on the falling edge.
  assign tick_clear = (state == IDLE);

  uart_baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign maj       = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign at_decide = tick && (samp_cnt == SAMPLE_DECIDE);
  assign at_end    = tick && (samp_cnt == BIT_END);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE:      if (!rxs) state_n = START;
      START: begin
        if (at_decide && maj) state_n = IDLE;
        else if (at_end)      state_n = DATA;
      end
      DATA:      if (at_end && bit_idx == 3'd7) state_n = STOP;
      // Leave at mid-stop-bit so a following start bit is never missed.
      STOP: begin
        if (at_decide) begin
          if (maj) begin
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      state       <= IDLE;
      samp_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      s_a         <= 1'b1;
      s_b         <= 1'b1;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      byte_data   <= '0;
      ui_value    <= UI_RESET;
    end else begin
      sync        <= {sync[0], rx_in};
      state       <= state_n;
      byte_valid  <= valid_n;
      framing_err <= err_n;

      if (state == IDLE) samp_cnt <= '0;
      else if (tick)     samp_cnt <= samp_cnt + 4'd1;

      if (tick && samp_cnt == SAMPLE_A) s_a <= rxs;
      if (tick && samp_cnt == SAMPLE_B) s_b <= rxs;

      if (state == DATA && at_decide) shift_reg <= {maj, shift_reg[7:1]};

      if (state == START && at_end)     bit_idx <= '0;
      else if (state == DATA && at_end) bit_idx <= bit_idx + 3'd1;

      if (valid_n) begin
        byte_data <= shift_reg;
        ui_value  <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_host_uart_ui_rx.sv
// Directed plus randomized bench; expected bytes/errors come from a frame-level model.
`timescale 1ns/1ps
module tb_host_uart_ui_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] ui_value, byte_data;
  logic       byte_valid, framing_err, busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         obs_err = 0;
  int         exp_err = 0;
  logic [7:0] exp_ui = 8'h00;
  int         viol = 0;
  logic       prev_v = 1'b0, prev_e = 1'b0;

  host_uart_ui_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .ui_value    (ui_value),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: collects strobes and flags overlapping or stretched pulses.
  always @(negedge clk) begin
    if (byte_valid) obs_q.push_back(byte_data);
    if (framing_err) obs_err++;
    if ((byte_valid && framing_err) || (byte_valid && prev_v) || (framing_err && prev_e)) viol++;
    prev_v = byte_valid;
    prev_e = framing_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bp);
    rx_in = 1'b0;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (bp) @(negedge clk);
    end
    rx_in = stop;
    repeat (bp) @(negedge clk);
    rx_in = 1'b1;
  endtask

  // Frame-level model: a good stop bit yields the byte and updates ui, a bad one an error.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back(b);
      exp_ui = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_phase(input string tag);
    logic [7:0] o, e;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_data"}, {24'd0, o}, {24'd0, e});
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_errs"}, obs_err, exp_err);
    check({tag, "_ui"}, {24'd0, ui_value}, {24'd0, exp_ui});
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         bp;

    // Reset
    rst = 1'b1; rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_ui",    {24'd0, ui_value}, 32'h00);
    check("rst_data",  {24'd0, byte_data}, 32'h00);
    check("rst_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_err",   {31'd0, framing_err}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single byte 0x5A
    send_frame(8'h5A, 1'b1, 864);
    model_frame(8'h5A, 1'b1);
    check("b5a_busy", {31'd0, busy}, 32'd0);
    check_phase("b5a");
    repeat (20) @(negedge clk);

    // Short low glitch is a false start
    rx_in = 1'b0;
    repeat (200) @(negedge clk);
    rx_in = 1'b1;
    wait_idle("glitch_busy", 16 * 54);
    check_phase("glitch");
    repeat (20) @(negedge clk);

    // Bad stop bit followed by a long break
    send_frame(8'h3C, 1'b0, 864);
    rx_in = 1'b0;
    model_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    check("brk_busy_hi", {31'd0, busy}, 32'd1);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_lo", {31'd0, busy}, 32'd0);
    check_phase("brk");
    repeat (20) @(negedge clk);

    // Back-to-back at +2% baud
    send_frame(8'h01, 1'b1, 847);
    send_frame(8'hFF, 1'b1, 847);
    model_frame(8'h01, 1'b1);
    model_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check_phase("b2b");

    // Reset in the middle of data bit 4 of an 0xF0 frame
    rx_in = 1'b0;
    repeat (864) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = 1'b0;
      repeat (864) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (432) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ui = 8'h00;
    check("abort_ui",   {24'd0, ui_value}, 32'h00);
    check("abort_data", {24'd0, byte_data}, 32'h00);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (1000) @(negedge clk);
    check_phase("abort");
    send_frame(8'h81, 1'b1, 864);
    model_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    check_phase("after_abort");

    // Randomized frames with baud skew and occasional bad stop bits
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      bp = $urandom_range(847, 881);
      send_frame(rb, rs, bp);
      model_frame(rb, rs);
      repeat (20 + $urandom_range(0, 40)) @(negedge clk);
      check_phase("rand");
    end

    check("pulse_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
